irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port src  input  8  interrupt sources, synchronous to clk, rising-edge sensitive.
REQ-004 SHALL have port ld_mask  input  1  load enable for the enable mask.
REQ-005 SHALL have port mask_in  input  8  new enable mask value.
REQ-006 SHALL have port mask  output  8  current enable mask; bit i=1 lets source i be dispatched.
REQ-007 SHALL have port pending  output  8  latched pending requests.
REQ-008 SHALL have port irq  output  1  registered interrupt request to cu.
REQ-009 SHALL have port vector  output  3  index of the dispatched source; stable while irq=1.
REQ-010 SHALL have port ack  input  1  cu acknowledge of the dispatched interrupt.
REQ-011 SHALL have port eoi  input  1  end of interrupt service.
REQ-012 SHALL have port in_service  output  1  high while a dispatched interrupt is being serviced.

Function
REQ-013 SHALL register src into src_q every cycle; pending[i] sets at the edge where src[i]=1 and src_q[i]=0, independent of mask.
REQ-014 SHALL implement states IDLE, PEND, SERVICE; irq=1 only in PEND, in_service=1 only in SERVICE.
REQ-015 SHALL go IDLE->PEND at the edge where (pending & mask)!=0, latching vector from the arbiter in the same edge.
REQ-016 SHALL make latency exactly 2 edges: src rises before edge k -> pending[i]=1 after k -> irq=1 after k+1.
REQ-017 SHALL, in PEND with ack=1, clear pending[vector], go to SERVICE, and drop irq at that edge.
REQ-018 SHALL, in SERVICE with eoi=1, return to IDLE; a further dispatch needs at least one IDLE cycle.
REQ-019 SHALL ignore ack outside PEND and eoi outside SERVICE.
REQ-020 SHALL keep pending[vector]=1 when a new rising edge on that source coincides with its ack clear; set wins.
REQ-021 SHALL update mask from mask_in at the edge where ld_mask=1, effective for arbitration in the following cycle.
REQ-022 SHALL NOT retract irq or change vector in PEND when the mask is cleared; the latched vector is still dispatched on ack.
REQ-023 SHALL use fixed priority by default: the lowest set index of (pending & mask) wins.
REQ-024 SHALL hold pending bits of masked sources indefinitely; unmasking them dispatches them normally.

Reset
REQ-025 SHALL, while rst=0, asynchronously force state=IDLE, mask=0, pending=0, src_q=0, vector=0, irq=0, in_service=0.
REQ-026 SHALL count a source already high at reset release as a rising edge at the first clock edge.
REQ-027 SHALL, on reset during PEND or SERVICE, abandon the interrupt with no residual pending bit.

Configuration
REQ-028 SHALL support macro IRQ_CTRL_ROUND_ROBIN_EN.
REQ-029 SHALL, with IRQ_CTRL_ROUND_ROBIN_EN defined, keep a 3-bit last pointer, reset to 7, updated to vector on ack.
REQ-030 SHALL, with IRQ_CTRL_ROUND_ROBIN_EN defined, search from index (last+1) mod 8 upward with wrap; without it, apply REQ-023 and omit the pointer.

Verification
REQ-031 SHALL cover: mask=FF, pulse src[3] before edge k -> pending=08 after k, irq=1 with vector=3 after k+1; ack -> pending=00, in_service=1; eoi -> IDLE.
REQ-032 SHALL cover: mask=FF, src[5] and src[2] rise in the same cycle -> vector=2 first; after ack and eoi -> vector=5.
REQ-033 SHALL cover: mask=00, src[1] rises -> pending=02, irq stays 0 for 10 cycles; load mask=02 -> irq=1 two edges later with vector=1.
REQ-034 SHALL cover: in PEND with vector=4, a new src[4] edge coincides with ack -> pending[4] stays 1 and is re-dispatched after eoi.
REQ-035 SHALL cover: rst=0 mid-SERVICE -> all outputs 0 immediately with no clock; src=01 held at release -> pending=01 after the first edge.
REQ-036 SHALL cover, with IRQ_CTRL_ROUND_ROBIN_EN: src[0] and src[1] re-pulsed after every eoi -> vectors alternate 0,1,0,1; without the macro -> vector always 0.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// Bundle of interrupt-controller signals between the control unit (master) and irq_ctrl (slave).
interface irq_ctrl_if;
    logic [7:0] src;
    logic       ld_mask;
    logic [7:0] mask_in;
    logic [7:0] mask;
    logic [7:0] pending;
    logic       irq;
    logic [2:0] vector;
    logic       ack;
    logic       eoi;
    logic       in_service;

    modport master (
        output src, ld_mask, mask_in, ack, eoi,
        input  mask, pending, irq, vector, in_service
    );

    modport slave (
        input  src, ld_mask, mask_in, ack, eoi,
        output mask, pending, irq, vector, in_service
    );
endinterface

// File: rtl/irq_ctrl.sv
// 8-source edge-latched interrupt controller with IDLE/PEND/SERVICE dispatch FSM.
// Define IRQ_CTRL_ROUND_ROBIN_EN for round-robin arbitration; default is fixed lowest-index priority.
module irq_ctrl (
    input  logic       clk,
    input  logic       rst,
    irq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_src_q;
    logic [7:0] r_mask;
    logic [7:0] r_pending;
    logic [2:0] r_vector;
    logic       r_irq;
    logic       r_in_service;

    logic [7:0] w_rise;
    logic [7:0] w_req;
    logic [7:0] w_clr;
    logic [2:0] w_sel;
    logic       w_ack;

    assign w_rise = bus.src & ~r_src_q;
    assign w_req  = r_pending & r_mask;
    assign w_clr  = w_ack ? (8'd1 << r_vector) : 8'd0;

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    logic [2:0] r_last;
    logic [2:0] w_idx;

    // Scan offsets downward so the candidate closest to last+1 is written last and wins.
    always_comb begin
        w_sel = 3'd0;
        w_idx = 3'd0;
        for (int off = 7; off >= 0; off--) begin
            w_idx = r_last + 3'(off) + 3'd1;
            if (w_req[w_idx]) w_sel = w_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_last <= 3'd7;
        else if (w_ack) r_last <= r_vector;
    end
`else
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_req[i]) w_sel = 3'(i);
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        w_ack  = 1'b0;
        case (r_state)
            IDLE:    if (|w_req) w_next = PEND;
            PEND: begin
                if (bus.ack) begin
                    w_next = SERVICE;
                    w_ack  = 1'b1;
                end
            end
            SERVICE: if (bus.eoi) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_src_q      <= 8'd0;
            r_mask       <= 8'd0;
            r_pending    <= 8'd0;
            r_vector     <= 3'd0;
            r_irq        <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_src_q      <= bus.src;
            // A new edge on the acknowledged source survives its own clear.
            r_pending    <= (r_pending & ~w_clr) | w_rise;
            r_irq        <= (w_next == PEND);
            r_in_service <= (w_next == SERVICE);
            if (bus.ld_mask) r_mask <= bus.mask_in;
            if (r_state == IDLE && w_next == PEND) r_vector <= w_sel;
        end
    end

    assign bus.mask       = r_mask;
    assign bus.pending    = r_pending;
    assign bus.irq        = r_irq;
    assign bus.vector     = r_vector;
    assign bus.in_service = r_in_service;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl with hand-computed expectations.
module tb_irq_ctrl;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    irq_ctrl_if bus ();

    irq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mask(input logic [7:0] m);
        bus.ld_mask = 1'b1;
        bus.mask_in = m;
        tick();
        bus.ld_mask = 1'b0;
    endtask

    task automatic ack_eoi();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_vec;
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b0;
        bus.src     = 8'h00;
        bus.ld_mask = 1'b0;
        bus.mask_in = 8'h00;
        bus.ack     = 1'b0;
        bus.eoi     = 1'b0;
        tick();
        check("rst_mask", bus.mask, 8'h00);
        check("rst_pending", bus.pending, 8'h00);
        check("rst_irq", {7'd0, bus.irq}, 8'h00);
        check("rst_insvc", {7'd0, bus.in_service}, 8'h00);
        check("rst_vector", {5'd0, bus.vector}, 8'h00);
        rst = 1'b1;
        tick();

        // Single source, two-edge latency.
        load_mask(8'hFF);
        check("mask_ff", bus.mask, 8'hFF);
        bus.src = 8'h08;
        tick();
        check("t1_pending", bus.pending, 8'h08);
        check("t1_irq_early", {7'd0, bus.irq}, 8'h00);
        bus.src = 8'h00;
        tick();
        check("t1_irq", {7'd0, bus.irq}, 8'h01);
        check("t1_vector", {5'd0, bus.vector}, 8'h03);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("t1_ack_pending", bus.pending, 8'h00);
        check("t1_ack_insvc", {7'd0, bus.in_service}, 8'h01);
        check("t1_ack_irq", {7'd0, bus.irq}, 8'h00);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        check("t1_eoi_insvc", {7'd0, bus.in_service}, 8'h00);
        check("t1_eoi_irq", {7'd0, bus.irq}, 8'h00);

        // Simultaneous sources 5 and 2: lowest index first.
        bus.src = 8'h24;
        tick();
        check("t2_pending", bus.pending, 8'h24);
        bus.src = 8'h00;
        tick();
        check("t2_vector_a", {5'd0, bus.vector}, 8'h02);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("t2_pending_a", bus.pending, 8'h20);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        check("t2_idle_gap", {7'd0, bus.irq}, 8'h00);
        tick();
        check("t2_irq_b", {7'd0, bus.irq}, 8'h01);
        check("t2_vector_b", {5'd0, bus.vector}, 8'h05);
        ack_eoi();
        check("t2_pending_end", bus.pending, 8'h00);

        // Masked source is held, dispatched once unmasked.
        load_mask(8'h00);
        bus.src = 8'h02;
        tick();
        bus.src = 8'h00;
        check("t3_pending", bus.pending, 8'h02);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_masked_irq", {7'd0, bus.irq}, 8'h00);
        end
        load_mask(8'h02);
        check("t3_irq_one_edge", {7'd0, bus.irq}, 8'h00);
        tick();
        check("t3_irq", {7'd0, bus.irq}, 8'h01);
        check("t3_vector", {5'd0, bus.vector}, 8'h01);
        ack_eoi();
        load_mask(8'hFF);

        // New edge on source 4 coincides with its ack: set wins.
        bus.src = 8'h10;
        tick();
        bus.src = 8'h00;
        tick();
        check("t4_vector", {5'd0, bus.vector}, 8'h04);
        bus.src = 8'h10;
        bus.ack = 1'b1;
        tick();
        bus.src = 8'h00;
        bus.ack = 1'b0;
        check("t4_pending_kept", bus.pending, 8'h10);
        check("t4_insvc", {7'd0, bus.in_service}, 8'h01);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        tick();
        check("t4_redispatch_irq", {7'd0, bus.irq}, 8'h01);
        check("t4_redispatch_vec", {5'd0, bus.vector}, 8'h04);
        ack_eoi();
        check("t4_pending_end", bus.pending, 8'h00);

        // Asynchronous reset in SERVICE, source held high through release.
        bus.src = 8'h42;
        tick();
        bus.src = 8'h00;
        tick();
        check("t5_vector", {5'd0, bus.vector}, 8'h01);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("t5_insvc", {7'd0, bus.in_service}, 8'h01);
        #2;
        rst     = 1'b0;
        bus.src = 8'h01;
        #1;
        check("t5_async_pending", bus.pending, 8'h00);
        check("t5_async_mask", bus.mask, 8'h00);
        check("t5_async_insvc", {7'd0, bus.in_service}, 8'h00);
        check("t5_async_irq", {7'd0, bus.irq}, 8'h00);
        check("t5_async_vector", {5'd0, bus.vector}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("t5_release_pending", bus.pending, 8'h01);
        check("t5_release_irq", {7'd0, bus.irq}, 8'h00);

        // Sources 0 and 1 re-raised with every eoi.
        rst = 1'b0;
        bus.src = 8'h00;
        #1;
        rst = 1'b1;
        tick();
        load_mask(8'hFF);
        bus.src = 8'h03;
        tick();
        bus.src = 8'h00;
        tick();
        check("t6_vector_0", {5'd0, bus.vector}, 8'h00);
        for (int r = 1; r < 4; r++) begin
            bus.ack = 1'b1;
            tick();
            bus.ack = 1'b0;
            bus.eoi = 1'b1;
            bus.src = 8'h03;
            tick();
            bus.eoi = 1'b0;
            bus.src = 8'h00;
            tick();
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
            exp_vec = 3'(r % 2);
`else
            exp_vec = 3'd0;
`endif
            check("t6_irq", {7'd0, bus.irq}, 8'h01);
            check("t6_vector", {5'd0, bus.vector}, {5'd0, exp_vec});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
